// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-core warp scheduler with round-robin single-slot issue
module warp_scheduler #(
  parameter int MAX_WARPS = 8,
  parameter int WARP_SIZE = 32,
  parameter int WID_W     = $clog2(MAX_WARPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [31:0]      block_id,
  input  logic [31:0]             block_dim,
  output logic                    done,
  output logic                    busy,
  output logic                    err,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [WID_W-1:0]        issue_warp_id,
  output logic [WARP_SIZE-1:0]    issue_thread_mask,
  output logic signed [31:0]      issue_block_id,
  input  logic                    report_valid,
  input  logic [WID_W-1:0]        report_warp_id,
  input  logic [1:0]              report_kind,
  input  logic                    wake_valid,
  input  logic [WID_W-1:0]        wake_warp_id
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} top_e;
  typedef enum logic [2:0] {W_INACTIVE, W_READY, W_IN_FLIGHT, W_WAITING, W_EXITED} warp_e;

  top_e                  st_q, st_d;
  warp_e                 wst_q [MAX_WARPS];
  warp_e                 wst_d [MAX_WARPS];
  logic [WID_W-1:0]      rr_q, rr_d;
  logic [WID_W-1:0]      last_wid_q, last_wid_d;
  logic [WARP_SIZE-1:0]  last_mask_q, last_mask_d;
  logic                  err_q, err_d;
  logic signed [31:0]    bid_q, bid_d;
  logic [31:0]           bdim_q, bdim_d;
  logic                  iv_q, iv_d;
  logic [WID_W-1:0]      iwid_q, iwid_d;
  logic [WARP_SIZE-1:0]  imask_q, imask_d;

  logic                  fire;
  logic [32:0]           nw_calc;
  logic [32:0]           rem_calc;
  logic [WID_W:0]        nw_new;
  logic                  all_exit;
  logic                  found;
  logic [WID_W-1:0]      pick;
  logic [WID_W-1:0]      scan_idx;

  assign fire = iv_q & issue_ready;

  // Next-state logic for the block FSM, per-warp states and the registered offer
  always_comb begin
    st_d        = st_q;
    wst_d       = wst_q;
    rr_d        = rr_q;
    last_wid_d  = last_wid_q;
    last_mask_d = last_mask_q;
    err_d       = err_q;
    bid_d       = bid_q;
    bdim_d      = bdim_q;
    iv_d        = 1'b0;
    iwid_d      = iwid_q;
    imask_d     = imask_q;
    nw_new      = '0;
    all_exit    = 1'b1;
    found       = 1'b0;
    pick        = '0;
    scan_idx    = '0;
    // 33-bit arithmetic so block_dim near 2^32 cannot wrap the warp count
    nw_calc  = ({1'b0, bdim_q} + 33'(WARP_SIZE - 1)) / 33'(WARP_SIZE);
    rem_calc = {1'b0, bdim_q} - ((nw_calc - 33'd1) * 33'(WARP_SIZE));

    case (st_q)
      S_IDLE: begin
        if (start) begin
          bid_d  = block_id;
          bdim_d = block_dim;
          st_d   = S_INIT;
        end
      end
      S_INIT: begin
        rr_d = '0;
        if (nw_calc > 33'(MAX_WARPS)) begin
          nw_new      = (WID_W+1)'(MAX_WARPS);
          err_d       = 1'b1;
          last_mask_d = '1;
        end else begin
          nw_new      = nw_calc[WID_W:0];
          // rem_calc is 1..WARP_SIZE; a shift by WARP_SIZE yields a full mask
          last_mask_d = ~({WARP_SIZE{1'b1}} << rem_calc);
        end
        last_wid_d = nw_new[WID_W-1:0] - WID_W'(1);
        for (int k = 0; k < MAX_WARPS; k++) begin
          wst_d[k] = ((WID_W+1)'(k) < nw_new) ? W_READY : W_INACTIVE;
        end
        st_d = (nw_new == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (fire) begin
          wst_d[iwid_q] = W_IN_FLIGHT;
          rr_d          = iwid_q + WID_W'(1);
        end
        // A warp being fired this cycle is still READY, so its report is dropped here
        if (report_valid && wst_q[report_warp_id] == W_IN_FLIGHT) begin
          case (report_kind)
            2'b00:   wst_d[report_warp_id] = W_READY;
            2'b01:   wst_d[report_warp_id] = W_WAITING;
            2'b10:   wst_d[report_warp_id] = W_EXITED;
            default: ;
          endcase
        end
        if (wake_valid && wst_q[wake_warp_id] == W_WAITING) begin
          wst_d[wake_warp_id] = W_READY;
        end
        for (int k = 0; k < MAX_WARPS; k++) begin
          if (wst_d[k] != W_EXITED && wst_d[k] != W_INACTIVE) all_exit = 1'b0;
        end
        if (all_exit) begin
          st_d = S_DONE;
        end else if (iv_q && !fire) begin
          // Offer is locked until the pipeline takes it
          iv_d = 1'b1;
        end else begin
          for (int i = 0; i < MAX_WARPS; i++) begin
            scan_idx = rr_d + WID_W'(i);
            if (!found && wst_q[scan_idx] == W_READY && !(fire && scan_idx == iwid_q)) begin
              found = 1'b1;
              pick  = scan_idx;
            end
          end
          iv_d = found;
          if (found) begin
            iwid_d  = pick;
            imask_d = (pick == last_wid_q) ? last_mask_q : '1;
          end
        end
      end
      S_DONE: begin
        if (!start) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any block in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= S_IDLE;
      for (int k = 0; k < MAX_WARPS; k++) wst_q[k] <= W_INACTIVE;
      rr_q        <= '0;
      last_wid_q  <= '0;
      last_mask_q <= '0;
      err_q       <= 1'b0;
      bid_q       <= '1;
      bdim_q      <= '0;
      iv_q        <= 1'b0;
      iwid_q      <= '0;
      imask_q     <= '0;
    end else begin
      st_q        <= st_d;
      wst_q       <= wst_d;
      rr_q        <= rr_d;
      last_wid_q  <= last_wid_d;
      last_mask_q <= last_mask_d;
      err_q       <= err_d;
      bid_q       <= bid_d;
      bdim_q      <= bdim_d;
      iv_q        <= iv_d;
      iwid_q      <= iwid_d;
      imask_q     <= imask_d;
    end
  end

  assign done              = (st_q == S_DONE);
  assign busy              = (st_q != S_IDLE);
  assign err               = err_q;
  assign issue_valid       = iv_q;
  assign issue_warp_id     = iwid_q;
  assign issue_thread_mask = imask_q;
  assign issue_block_id    = bid_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - self-checking bench for warp_scheduler with a cycle reference model
module tb_warp_scheduler;
  localparam int MW = 8;
  localparam int WS = 32;
  localparam int INA = 0, RDY = 1, FLT = 2, WAI = 3, EXT = 4;
  localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_DONE = 3;

  logic clk = 1'b0, rst, start;
  logic signed [31:0] block_id;
  logic [31:0] block_dim;
  logic done, busy, err, issue_valid, issue_ready;
  logic [2:0] issue_warp_id;
  logic [WS-1:0] issue_thread_mask;
  logic signed [31:0] issue_block_id;
  logic report_valid, wake_valid;
  logic [2:0] report_warp_id, wake_warp_id;
  logic [1:0] report_kind;

  warp_scheduler #(.MAX_WARPS(MW), .WARP_SIZE(WS)) dut (
    .clk(clk), .rst(rst), .start(start), .block_id(block_id), .block_dim(block_dim),
    .done(done), .busy(busy), .err(err), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_warp_id(issue_warp_id), .issue_thread_mask(issue_thread_mask),
    .issue_block_id(issue_block_id), .report_valid(report_valid), .report_warp_id(report_warp_id),
    .report_kind(report_kind), .wake_valid(wake_valid), .wake_warp_id(wake_warp_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int tcount = 0, cyc_in_block = 0, n_iv = 0, first_done = -1;
  int dut_ids[$];
  logic [WS-1:0] dut_masks[$];
  int fq_id[$], fq_t[$];

  // reference model state
  int m_phase, m_rr, m_oid, m_nw, m_bid;
  int m_ws[MW];
  bit m_iv, m_err, m_trunc;
  longint m_dim;
  logic [WS-1:0] m_omask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lanes covered by warp k = threads left after the k full warps before it
  function automatic logic [WS-1:0] exp_mask(input int k);
    longint lanes;
    if (m_trunc) return '1;
    lanes = m_dim - longint'(WS) * k;
    if (lanes >= WS) return '1;
    return (32'd1 << lanes) - 32'd1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_rr = 0; m_oid = 0; m_nw = 0; m_bid = -1;
    m_iv = 0; m_err = 0; m_trunc = 0; m_dim = 0; m_omask = '0;
    for (int k = 0; k < MW; k++) m_ws[k] = INA;
  endtask

  task automatic model_step();
    int nws[MW];
    int pick;
    bit fire, finished;
    longint q;
    fire = m_iv && issue_ready;
    case (m_phase)
      P_IDLE: if (start) begin
        m_bid = block_id; m_dim = longint'(block_dim); m_phase = P_INIT;
      end
      P_INIT: begin
        q = (m_dim + WS - 1) / WS;
        m_trunc = (q > MW);
        if (m_trunc) m_err = 1;
        m_nw = m_trunc ? MW : int'(q);
        for (int k = 0; k < MW; k++) m_ws[k] = (k < m_nw) ? RDY : INA;
        m_rr = 0;
        m_phase = (m_nw == 0) ? P_DONE : P_RUN;
      end
      P_RUN: begin
        nws = m_ws;
        if (fire) begin
          nws[m_oid] = FLT; m_rr = (m_oid + 1) % MW;
          fq_id.push_back(m_oid); fq_t.push_back(tcount);
        end
        if (report_valid && m_ws[report_warp_id] == FLT) begin
          if (report_kind == 2'b00) nws[report_warp_id] = RDY;
          else if (report_kind == 2'b01) nws[report_warp_id] = WAI;
          else if (report_kind == 2'b10) nws[report_warp_id] = EXT;
        end
        if (wake_valid && m_ws[wake_warp_id] == WAI) nws[wake_warp_id] = RDY;
        pick = -1;
        for (int j = 0; j < MW; j++) begin
          int k;
          k = (m_rr + j) % MW;
          if (pick < 0 && m_ws[k] == RDY && !(fire && k == m_oid)) pick = k;
        end
        m_ws = nws;
        finished = 1;
        for (int k = 0; k < m_nw; k++) if (m_ws[k] != EXT) finished = 0;
        if (finished) begin
          m_phase = P_DONE; m_iv = 0;
        end else if (m_iv && !fire) begin
          m_iv = 1;
        end else if (pick >= 0) begin
          m_iv = 1; m_oid = pick; m_omask = exp_mask(pick);
        end else begin
          m_iv = 0;
        end
      end
      default: if (!start) m_phase = P_IDLE;
    endcase
  endtask

  task automatic cycle();
    chk("issue_valid", issue_valid, m_iv);
    if (m_iv) begin
      chk("issue_warp_id", issue_warp_id, m_oid);
      chk("issue_thread_mask", issue_thread_mask, m_omask);
    end
    chk("done", done, m_phase == P_DONE);
    chk("busy", busy, m_phase != P_IDLE);
    chk("err", err, m_err);
    chk("issue_block_id", issue_block_id, m_bid);
    if (issue_valid && issue_ready) begin
      dut_ids.push_back(int'(issue_warp_id)); dut_masks.push_back(issue_thread_mask);
    end
    if (issue_valid) n_iv++;
    if (done && first_done < 0) first_done = cyc_in_block;
    if (rst) model_reset(); else model_step();
    tcount++;
    @(negedge clk);
  endtask

  // mode 1: always ready, exit each warp two cycles after it fires; mode 0: random pipeline
  task automatic set_inputs(input int mode);
    int fl[$], wl[$];
    report_valid = 0; report_warp_id = 0; report_kind = 0; wake_valid = 0; wake_warp_id = 0;
    if (mode == 1) begin
      issue_ready = 1;
      if (fq_t.size() > 0 && fq_t[0] == tcount - 2) begin
        report_valid = 1; report_warp_id = 3'(fq_id[0]); report_kind = 2'b10;
        void'(fq_t.pop_front()); void'(fq_id.pop_front());
      end
    end else begin
      int r;
      issue_ready = ($urandom_range(3) != 0);
      for (int k = 0; k < MW; k++) begin
        if (m_ws[k] == FLT) fl.push_back(k);
        if (m_ws[k] == WAI) wl.push_back(k);
      end
      if ($urandom_range(1) == 1) begin
        report_valid = 1;
        if (fl.size() > 0 && $urandom_range(3) != 0) report_warp_id = 3'(fl[$urandom_range(fl.size() - 1)]);
        else report_warp_id = 3'($urandom_range(MW - 1));
        r = $urandom_range(9);
        report_kind = (r < 4) ? 2'b10 : (r < 7) ? 2'b00 : (r < 9) ? 2'b01 : 2'b11;
      end
      if ($urandom_range(2) == 0) begin
        wake_valid = 1;
        if (wl.size() > 0 && $urandom_range(1) == 1) wake_warp_id = 3'(wl[$urandom_range(wl.size() - 1)]);
        else wake_warp_id = 3'($urandom_range(MW - 1));
      end
    end
  endtask

  task automatic run_block(input logic [31:0] dim, input int mode, input int abort_after);
    bit fin;
    fin = 0;
    dut_ids.delete(); dut_masks.delete(); fq_id.delete(); fq_t.delete();
    n_iv = 0; first_done = -1;
    block_id = $urandom; block_dim = dim; start = 1;
    for (int c = 0; c < 3000; c++) begin
      cyc_in_block = c;
      if (abort_after > 0 && c == abort_after) begin fin = 1; break; end
      if (m_phase == P_DONE) start = 0;
      else if (m_phase == P_IDLE && c > 0) begin fin = 1; break; end
      set_inputs(mode);
      cycle();
    end
    chk("block_completes", fin, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_issue_valid"}, issue_valid, 1'b0);
    chk({tag, "_issue_warp_id"}, issue_warp_id, 3'd0);
    chk({tag, "_issue_thread_mask"}, issue_thread_mask, 32'd0);
    chk({tag, "_issue_block_id"}, issue_block_id, -64'sd1);
  endtask

  initial begin
    rst = 1; start = 0; block_id = 0; block_dim = 0; issue_ready = 0;
    report_valid = 0; report_warp_id = 0; report_kind = 0; wake_valid = 0; wake_warp_id = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("por");
    rst = 0;

    // 70 threads: three warps, last one has 6 lanes
    run_block(32'd70, 1, 0);
    chk("A_nfires", dut_ids.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("A_fire%0d_id", i), (i < dut_ids.size()) ? dut_ids[i] : -1, i);
      chk($sformatf("A_fire%0d_mask", i), (i < dut_masks.size()) ? dut_masks[i] : 32'hDEAD, (i < 2) ? 32'hFFFF_FFFF : 32'h0000_003F);
    end
    chk("A_err", err, 1'b0);
    chk("A_block_id", issue_block_id, block_id);

    // empty block goes straight to done
    run_block(32'd0, 0, 0);
    chk("B_done_latency", first_done, 2);
    chk("B_no_issue", n_iv, 0);

    for (int b = 0; b < 6; b++) run_block(32'($urandom_range(256)), 0, 0);
    run_block(32'd256, 0, 0);
    run_block(32'd33, 0, 0);

    // oversize block truncates to MAX_WARPS full warps and latches err
    run_block(32'd300, 1, 0);
    chk("C_nfires", dut_ids.size(), MW);
    for (int i = 0; i < MW; i++) begin
      chk($sformatf("C_fire%0d_id", i), (i < dut_ids.size()) ? dut_ids[i] : -1, i);
      chk($sformatf("C_fire%0d_mask", i), (i < dut_masks.size()) ? dut_masks[i] : 32'hDEAD, 32'hFFFF_FFFF);
    end
    chk("C_err", err, 1'b1);
    run_block(32'd50, 0, 0);
    chk("C_err_sticky", err, 1'b1);

    // asynchronous reset in the middle of a busy block
    run_block(32'd200, 0, 25);
    chk("D_busy_before_rst", busy, 1'b1);
    start = 0;
    rst = 1;
    model_reset();
    #1;
    chk_reset_outputs("async_rst");
    for (int i = 0; i < 3; i++) begin set_inputs(0); cycle(); end
    rst = 0;
    for (int i = 0; i < 4; i++) begin set_inputs(0); cycle(); end
    chk_reset_outputs("post_rst");
    run_block(32'd100, 0, 0);
    chk("D_err_after_rst", err, 1'b0);
    run_block(32'd256, 1, 0);
    chk("D_nfires_full", dut_ids.size(), MW);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Per-compute-unit warp scheduler that sits between the block dispatcher and the core's shared execution pipeline. On a block assignment it splits the block's threads into warps, tracks each warp's state, and grants the single issue slot to one ready warp per cycle in round-robin order. It reports block completion back to the dispatcher once every warp has exited.

## Interface
- MAX_WARPS, 8: warp slots per core (power of two, ≥2)
- WARP_SIZE, 32: threads per warp; thread-mask width
- WID_W, $clog2(MAX_WARPS): warp-id width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; block assigned (dispatcher core_start for this core)
- block_id  in  32 signed  assigned block id, sampled in IDLE when start=1
- block_dim  in  32  threads per block, sampled with block_id
- done  out  1  block finished (dispatcher core_done for this core)
- busy  out  1  state ≠ IDLE
- err  out  1  sticky: block_dim exceeded MAX_WARPS*WARP_SIZE; cleared only by reset
- issue_valid  out  1  a warp is offered to the pipeline
- issue_ready  in  1  pipeline accepts; fire = issue_valid & issue_ready
- issue_warp_id  out  WID_W  offered warp
- issue_thread_mask  out  WARP_SIZE  active lanes of offered warp
- issue_block_id  out  32 signed  latched block id
- report_valid  in  1  pipeline outcome for an in-flight warp
- report_warp_id  in  WID_W
- report_kind  in  2  00 complete, 01 stall, 10 exit, 11 ignored
- wake_valid  in  1  memory returned for a waiting warp
- wake_warp_id  in  WID_W

## Operation
- Top FSM: IDLE → INIT → RUN → DONE → IDLE.
- IDLE: start=1 latches block_id/block_dim → INIT. start=0 stays.
- INIT (1 cycle): nw = ceil(block_dim / WARP_SIZE), computed in 33 bits (no overflow). If nw > MAX_WARPS: nw = MAX_WARPS, err ← 1. Warps 0..nw-1 → READY, the rest INACTIVE. rr pointer ← 0. nw = 0 → DONE directly.
- Thread masks: warp k < nw-1 all ones. Last warp: low r bits set, r = block_dim − (nw−1)*WARP_SIZE (1..WARP_SIZE). On truncation all masks are full.
- Per-warp state: INACTIVE, READY, IN_FLIGHT, WAITING, EXITED.
- Fire: the offered warp goes READY → IN_FLIGHT; rr pointer ← offered id + 1 (mod MAX_WARPS).
- Report applies only to an IN_FLIGHT warp: complete → READY, stall → WAITING, exit → EXITED. On any other state the report is ignored.
- Wake applies only to a WAITING warp (→ READY). Otherwise it is ignored.
- Report and wake in the same cycle for different warps both apply. For the same warp, at most one can be legal; only the legal one applies.
- RUN → DONE when all warps 0..nw-1 are EXITED, including same-cycle updates.
- DONE: done=1. Hold until start=0, then → IDLE (done=0). No issue in DONE/IDLE/INIT.

## Timing
- Reset (async): state IDLE, all warps INACTIVE, rr=0. Outputs: done=0, busy=0, err=0, issue_valid=0, issue_warp_id=0, issue_thread_mask=0, issue_block_id=−1.
- Reset mid-RUN aborts the block immediately. In-flight reports arriving afterwards are ignored.
- issue_valid is registered. In RUN it is asserted the cycle after any warp is READY. The offered warp is the first READY warp scanning from rr upward with wrap.
- Offer lock: once issue_valid=1 and not fired, issue_warp_id and issue_thread_mask stay stable until fire, even if other warps become READY.
- After a fire the next offer can appear on the following cycle, so back-to-back issue at one warp per cycle is possible with ready held high.
- start=1 → first issue_valid no earlier than 2 cycles later (IDLE→INIT→RUN). Last exit report → done=1 on the next edge.
- A report on the fire cycle for the warp being fired is ignored, because that warp is not yet IN_FLIGHT.

## Test plan
- block_dim=70, WARP_SIZE=32, issue_ready=1, each issue reported exit 2 cycles later -> issues warp 0,1,2 with masks FFFFFFFF, FFFFFFFF, 0000003F; done=1; err=0; issue_block_id = latched value.
- 4 warps, warp 1 reports stall, others report complete -> order 0,1,2,3,0,2,3,… skips warp 1 until wake_warp_id=1, then warp 1 is offered at its rr turn.
- issue_ready=0 for 5 cycles while offering warp 2; wake warp 1 during the hold -> issue_warp_id stays 2 until fire; the next offer is warp 1 (wrap from rr=3).
- block_dim=0 -> no issue_valid ever; done=1 two cycles after start; start low -> done=0, busy=0.
- MAX_WARPS=8, block_dim=300 -> err=1; exactly 8 warps issued, all masks full; err persists across a following block until rst.
- rst asserted mid-RUN with warps IN_FLIGHT/WAITING -> all outputs at reset values without a clock edge; later reports/wakes ignored; a new start runs cleanly.
